// File: rtl/arbmux.sv
// arbmux: select and state types for the physical-memory arbiter.
//   arb_sel_t    - which cache owns the pmem port (icache / dcache)
//   arb_state_t  - arbiter FSM states
//   arb_pick()   - IDLE-state winner selection, shared by both arbitration modes
// Round-robin arbitration is enabled by defining PMEM_ARB_RR_EN.
package arbmux;

    typedef enum logic {
        icache = 1'b0,
        dcache = 1'b1
    } arb_sel_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ICACHE = 2'd1,
        ARB_DCACHE = 2'd2
    } arb_state_t;

    // Low address bits that select a byte within a 256-bit line.
    localparam int unsigned LINE_OFFSET_W = 5;

    // Winner of one IDLE arbitration. Only meaningful when i_req or d_req is set.
    // In round-robin mode a tie goes to the requester that did not win last time;
    // otherwise the D-cache wins ties, since a D miss stalls the whole pipe.
    function automatic arb_sel_t arb_pick(input logic     i_req,
                                          input logic     d_req,
                                          input logic     rr_mode,
                                          input arb_sel_t last_grant);
        arb_sel_t win;
        if (i_req && d_req) begin
            if (rr_mode) begin
                win = (last_grant == icache) ? dcache : icache;
            end else begin
                win = dcache;
            end
        end else if (d_req) begin
            win = dcache;
        end else begin
            win = icache;
        end
        return win;
    endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the single line-wide physical memory port between the
// I-cache (read only) and the D-cache (read + writeback).
//
// A three-state FSM (ARB_IDLE / ARB_ICACHE / ARB_DCACHE) grants one requester
// at a time and holds the grant until pmem_resp. Every transaction passes
// through one IDLE cycle, so back-to-back requests see exactly one bubble.
//
// Configuration:
//   PMEM_ARB_RR_EN defined   - round-robin on contention (tracks last_grant)
//   PMEM_ARB_RR_EN undefined - fixed D-over-I priority
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   i_read/i_addr               I-cache line read request (held until i_resp)
//   i_rdata/i_resp              line and one-cycle completion pulse to I-cache
//   d_read/d_write/d_addr       D-cache read / writeback request (held until d_resp)
//   d_wdata                     D-cache writeback line
//   d_rdata/d_resp              line and one-cycle completion pulse to D-cache
//   pmem_read/pmem_write        pmem strobes, held until pmem_resp
//   pmem_address/pmem_wdata     line-aligned address and writeback data
//   pmem_rdata/pmem_resp        returned line and one-cycle completion
module pmem_arbiter
    import arbmux::*;
#(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [ADDR_W-1:0] OffsetMask = ADDR_W'((1 << LINE_OFFSET_W) - 1);

    arb_state_t        state_q;
    logic              write_q;     // granted D transaction is a writeback
    logic [ADDR_W-1:0] addr_q;      // line address latched at grant
    logic [LINE_W-1:0] i_rdata_q;   // last line returned to each requester
    logic [LINE_W-1:0] d_rdata_q;

    logic     i_req;
    logic     d_req;
    arb_sel_t win;
    logic     grant_i;
    logic     grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef PMEM_ARB_RR_EN
    arb_sel_t last_grant_q;
    assign win = arb_pick(i_req, d_req, 1'b1, last_grant_q);
`else
    assign win = arb_pick(i_req, d_req, 1'b0, icache);
`endif

    // FSM and latched transaction state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef PMEM_ARB_RR_EN
            last_grant_q <= icache;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (i_req || d_req) begin
                        if (win == dcache) begin
                            state_q <= ARB_DCACHE;
                            addr_q  <= d_addr & ~OffsetMask;
                            // A writeback wins over a read if both are raised.
                            write_q <= d_write;
                        end else begin
                            state_q <= ARB_ICACHE;
                            addr_q  <= i_addr & ~OffsetMask;
                            write_q <= 1'b0;
                        end
`ifdef PMEM_ARB_RR_EN
                        last_grant_q <= win;
`endif
                    end
                end
                ARB_ICACHE: begin
                    if (pmem_resp) begin
                        state_q   <= ARB_IDLE;
                        i_rdata_q <= pmem_rdata;
                    end
                end
                ARB_DCACHE: begin
                    if (pmem_resp) begin
                        state_q   <= ARB_IDLE;
                        d_rdata_q <= pmem_rdata;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign grant_i = (state_q == ARB_ICACHE);
    assign grant_d = (state_q == ARB_DCACHE);

    // Output mux. Because everything is gated by state_q, an asynchronous reset
    // drops the strobes and responses immediately.
    always_comb begin
        pmem_read    = grant_i | (grant_d & ~write_q);
        pmem_write   = grant_d & write_q;
        pmem_address = (grant_i | grant_d) ? addr_q : '0;
        pmem_wdata   = (grant_d & write_q) ? d_wdata : '0;

        i_resp  = grant_i & pmem_resp;
        d_resp  = grant_d & pmem_resp;
        // The returned line is visible in the resp cycle and held afterwards.
        i_rdata = i_resp ? pmem_rdata : i_rdata_q;
        d_rdata = d_resp ? pmem_rdata : d_rdata_q;
    end

    // Protocol checks
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(d_read && d_write));
    a_i_req_held: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ARB_ICACHE) |-> i_read);
    a_d_req_held: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ARB_DCACHE) |-> (d_read || d_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter. Inputs change 1 time unit after the rising
// edge; outputs are checked 1 time unit later, away from the edge.
module tb_pmem_arbiter;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    localparam logic [LINE_W-1:0] LineA = {8{32'hDEADBEEF}};
    localparam logic [LINE_W-1:0] LineB = {8{32'h0BADF00D}};
    localparam logic [LINE_W-1:0] LineC = {8{32'h13579BDF}};
    localparam logic [LINE_W-1:0] LineD = {8{32'h2468ACE0}};
    localparam logic [LINE_W-1:0] LineW = {32{8'hA5}};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    pmem_arbiter #(
        .LINE_W(LINE_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise pmem_resp with a line for the current cycle, then settle.
    task automatic resp_on(input logic [LINE_W-1:0] line);
        pmem_rdata = line;
        pmem_resp  = 1'b1;
        #1;
    endtask

    // Advance past the resp cycle and drop pmem_resp.
    task automatic resp_off();
        tick();
        pmem_resp = 1'b0;
        #1;
    endtask

    initial begin
        // ---------------- reset state
        #12;
        check("rst_pmem_read", LINE_W'(pmem_read), '0);
        check("rst_pmem_write", LINE_W'(pmem_write), '0);
        check("rst_address", LINE_W'(pmem_address), '0);
        check("rst_resps", LINE_W'({i_resp, d_resp}), '0);
        check("rst_rdata", i_rdata | d_rdata, '0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- 1: I-only read, pmem latency 4
        tick();
        i_read = 1'b1;
        i_addr = 32'h6000_0044;
        #1;
        check("t1_idle_no_strobe", LINE_W'(pmem_read), '0);
        tick();
        check("t1_grant_read", LINE_W'(pmem_read), 1);
        check("t1_address", LINE_W'(pmem_address), LINE_W'(32'h6000_0040));
        check("t1_no_write", LINE_W'(pmem_write), '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t1_wait_no_resp", LINE_W'({i_resp, d_resp}), '0);
        end
        tick();
        resp_on(LineA);
        check("t1_i_resp", LINE_W'(i_resp), 1);
        check("t1_d_resp", LINE_W'(d_resp), '0);
        check("t1_i_rdata", i_rdata, LineA);
        check("t1_d_rdata_held", d_rdata, '0);
        resp_off();
        i_read = 1'b0;
        #1;
        check("t1_after_idle", LINE_W'({pmem_read, i_resp}), '0);
        check("t1_i_rdata_held", i_rdata, LineA);

        // ---------------- 2: simultaneous, last_grant=icache: D first in both modes
        i_read = 1'b1;
        i_addr = 32'h0000_1100;
        d_read = 1'b1;
        d_addr = 32'h0000_2200;
        tick();
        check("t2_first_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_2200));
        resp_on(LineB);
        check("t2_d_resp", LINE_W'(d_resp), 1);
        check("t2_i_no_resp", LINE_W'(i_resp), '0);
        check("t2_d_rdata", d_rdata, LineB);
        check("t2_i_rdata_held", i_rdata, LineA);
        resp_off();
        d_read = 1'b0;
        #1;
        check("t2_bubble", LINE_W'(pmem_read), '0);
        tick();
        check("t2_second_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_1100));
        check("t2_second_read", LINE_W'(pmem_read), 1);
        resp_on(LineC);
        check("t2_second_resp", LINE_W'({i_resp, d_resp}), LINE_W'(2'b10));
        resp_off();
        i_read = 1'b0;

        // ---------------- 3: writeback
        d_write = 1'b1;
        d_addr  = 32'h1234_567F;
        d_wdata = LineW;
        tick();
        check("t3_write", LINE_W'(pmem_write), 1);
        check("t3_no_read", LINE_W'(pmem_read), '0);
        check("t3_wdata", pmem_wdata, LineW);
        check("t3_address", LINE_W'(pmem_address), LINE_W'(32'h1234_5660));
        tick();
        check("t3_wait", LINE_W'({pmem_read, d_resp}), '0);
        tick();
        resp_on(LineD);
        check("t3_d_resp", LINE_W'({i_resp, d_resp}), LINE_W'(2'b01));
        resp_off();
        d_write = 1'b0;
        d_wdata = '0;
        #1;
        check("t3_write_drop", LINE_W'(pmem_write), '0);

        // ---------------- 2b: simultaneous with last_grant=dcache
        i_read = 1'b1;
        i_addr = 32'h0000_3300;
        d_read = 1'b1;
        d_addr = 32'h0000_4400;
        tick();
`ifdef PMEM_ARB_RR_EN
        check("t2b_first_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_3300));
        resp_on(LineA);
        check("t2b_first_resp", LINE_W'({i_resp, d_resp}), LINE_W'(2'b10));
        resp_off();
        i_read = 1'b0;
        tick();
        check("t2b_second_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_4400));
        resp_on(LineB);
        resp_off();
        d_read = 1'b0;
`else
        check("t2b_first_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_4400));
        resp_on(LineA);
        check("t2b_first_resp", LINE_W'({i_resp, d_resp}), LINE_W'(2'b01));
        resp_off();
        d_read = 1'b0;
        tick();
        check("t2b_second_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_3300));
        resp_on(LineB);
        resp_off();
        i_read = 1'b0;
`endif

        // ---------------- 4: back-to-back D, address change during grant ignored
        d_read = 1'b1;
        d_addr = 32'h0000_5500;
        tick();
        d_addr = 32'h0000_6600;
        #1;
        check("t4_addr_latched", LINE_W'(pmem_address), LINE_W'(32'h0000_5500));
        resp_on(LineC);
        check("t4_first_resp", LINE_W'(d_resp), 1);
        resp_off();
        check("t4_bubble", LINE_W'({pmem_read, d_resp}), '0);
        tick();
        check("t4_second_grant", LINE_W'(pmem_read), 1);
        check("t4_second_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_6600));
        resp_on(LineD);
        check("t4_second_rdata", d_rdata, LineD);
        resp_off();
        d_read = 1'b0;

        // ---------------- 5: D continuous, I once (last_grant=dcache)
        d_read = 1'b1;
        d_addr = 32'h0000_7700;
        i_read = 1'b1;
        i_addr = 32'h0000_8800;
        tick();
`ifdef PMEM_ARB_RR_EN
        // last_grant is dcache here, so I wins the first arbitration
        check("t5_first_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_8800));
        resp_on(LineA);
        resp_off();
        i_read = 1'b0;
        tick();
        check("t5_second_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_7700));
        resp_on(LineB);
        resp_off();
        d_read = 1'b0;
`else
        check("t5_first_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_7700));
        resp_on(LineA);
        resp_off();
        tick();
        check("t5_d_again", LINE_W'(pmem_address), LINE_W'(32'h0000_7700));
        resp_on(LineB);
        check("t5_i_waits", LINE_W'({i_resp, d_resp}), LINE_W'(2'b01));
        resp_off();
        d_read = 1'b0;
        tick();
        check("t5_i_after_gap", LINE_W'(pmem_address), LINE_W'(32'h0000_8800));
        resp_on(LineC);
        check("t5_i_resp", LINE_W'(i_resp), 1);
        resp_off();
        i_read = 1'b0;
`endif

        // ---------------- 6: reset mid-transaction
        i_read = 1'b1;
        i_addr = 32'h0000_9900;
        tick();
        check("t6_read_up", LINE_W'(pmem_read), 1);
        #2;
        rst = 1'b0;
        pmem_rdata = LineD;
        pmem_resp  = 1'b1;
        #1;
        check("t6_read_dropped", LINE_W'(pmem_read), '0);
        check("t6_no_resp", LINE_W'({i_resp, d_resp}), '0);
        check("t6_addr_cleared", LINE_W'(pmem_address), '0);
        i_read    = 1'b0;
        pmem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("t6_idle", LINE_W'({pmem_read, pmem_write}), '0);
        check("t6_rdata_cleared", i_rdata, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
